// File: rtl/video_pkg.sv
// Shared defaults and helpers for the VGA test-pattern blocks.
package video_pkg;

    localparam int H_SIZE_DEF = 640;
    localparam int V_SIZE_DEF = 480;
    localparam int CW_DEF     = 12;
    localparam int HALF_BASE  = 16;
    localparam int COORD_W    = 11;
    localparam int HALF_W     = 8;

    // Square half-size in pixels: 16, 32, 64 or 128
    function automatic logic [HALF_W-1:0] half_size(input logic [1:0] sel);
        logic [HALF_W-1:0] base;
        base = HALF_W'(HALF_BASE);
        return base << sel;
    endfunction

endpackage

// File: rtl/sq_axis_mover.sv
// One axis of the bouncing square: centre, direction and the per-frame step/clamp/flip.
module sq_axis_mover
    import video_pkg::*;
#(
    parameter int SIZE  = 640,
    parameter int WIDTH = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              move_en,
    input  logic [3:0]        speed,
    input  logic [HALF_W-1:0] h,
    output logic [WIDTH-1:0]  c,
    output logic              dir,
    output logic              hit
);

    localparam logic [WIDTH-1:0] C_RST = WIDTH'(SIZE / 2);

    logic [WIDTH-1:0]        c_r;
    logic                    dir_r;
    logic [WIDTH-1:0]        c_nxt_s;
    logic                    dir_nxt_s;
    logic                    hit_s;
    logic signed [WIDTH:0]   cur_s;
    logic signed [WIDTH:0]   step_s;
    logic signed [WIDTH:0]   cand_s;
    logic signed [WIDTH:0]   max_s;
    logic signed [WIDTH:0]   min_s;

    // Candidate position in one extra signed bit so a step past zero cannot wrap; dir_r = 1 means moving negative
    always_comb begin
        c_nxt_s   = c_r;
        dir_nxt_s = dir_r;
        hit_s     = 1'b0;
        cur_s     = $signed({1'b0, c_r});
        if (move_en) begin
            step_s = $signed((WIDTH+1)'(speed));
        end else begin
            step_s = {(WIDTH+1){1'b0}};
        end
        if (dir_r) begin
            cand_s = cur_s - step_s;
        end else begin
            cand_s = cur_s + step_s;
        end
        max_s = $signed((WIDTH+1)'(SIZE - 1)) - $signed((WIDTH+1)'(h));
        min_s = $signed((WIDTH+1)'(h));
        if (cand_s > max_s) begin
            c_nxt_s   = WIDTH'(max_s);
            dir_nxt_s = 1'b1;
            hit_s     = 1'b1;
        end else if (cand_s < min_s) begin
            c_nxt_s   = WIDTH'(min_s);
            dir_nxt_s = 1'b0;
            hit_s     = 1'b1;
        end else begin
            c_nxt_s   = WIDTH'(cand_s);
            dir_nxt_s = dir_r;
        end
    end

    // Centre and direction only change on the frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            c_r   <= C_RST;
            dir_r <= 1'b0;
        end else if (frame_start) begin
            c_r   <= c_nxt_s;
            dir_r <= dir_nxt_s;
        end else begin
            c_r   <= c_r;
            dir_r <= dir_r;
        end
    end

    assign c   = c_r;
    assign dir = dir_r;
    assign hit = hit_s;

endmodule

// File: rtl/square_bounce_gen.sv
// Moving-square test pattern: two axis movers, strict-inside pixel test, registered colour and bounce counter.
module square_bounce_gen
    import video_pkg::*;
#(
    parameter int H_SIZE = H_SIZE_DEF,
    parameter int V_SIZE = V_SIZE_DEF,
    parameter int CW     = CW_DEF,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               frame_start,
    input  logic [1:0]         sq_size,
    input  logic [CW-1:0]      sq_color,
    input  logic               move_en,
    input  logic [3:0]         speed,
    output logic [CW-1:0]      sq_rgb,
    output logic [CNT_W-1:0]   bounce_cnt
);

    localparam int PW = COORD_W + 2;

    logic [HALF_W-1:0]  half_s;
    logic [COORD_W-1:0] cx_s;
    logic [COORD_W-1:0] cy_s;
    logic               dx_s;
    logic               dy_s;
    logic               hit_x_s;
    logic               hit_y_s;
    logic               inside_s;
    logic signed [PW-1:0] xs_s;
    logic signed [PW-1:0] ys_s;
    logic signed [PW-1:0] cxs_s;
    logic signed [PW-1:0] cys_s;
    logic signed [PW-1:0] hs_s;
    logic [CW-1:0]      sq_rgb_r;
    logic [CNT_W-1:0]   bounce_cnt_r;

    assign half_s = half_size(sq_size);

    sq_axis_mover #(.SIZE(H_SIZE), .WIDTH(COORD_W)) u_x (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .move_en     (move_en),
        .speed       (speed),
        .h           (half_s),
        .c           (cx_s),
        .dir         (dx_s),
        .hit         (hit_x_s)
    );

    sq_axis_mover #(.SIZE(V_SIZE), .WIDTH(COORD_W)) u_y (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .move_en     (move_en),
        .speed       (speed),
        .h           (half_s),
        .c           (cy_s),
        .dir         (dy_s),
        .hit         (hit_y_s)
    );

    // Signed compare so a centre closer than h to an edge (after a resize) still tests correctly
    always_comb begin
        xs_s     = $signed({2'b00, x});
        ys_s     = $signed({2'b00, y});
        cxs_s    = $signed({2'b00, cx_s});
        cys_s    = $signed({2'b00, cy_s});
        hs_s     = $signed(PW'(half_s));
        inside_s = (xs_s > cxs_s - hs_s) && (xs_s < cxs_s + hs_s) &&
                   (ys_s > cys_s - hs_s) && (ys_s < cys_s + hs_s);
    end

    // Output colour register and per-frame bounce counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_rgb_r     <= {CW{1'b0}};
            bounce_cnt_r <= {CNT_W{1'b0}};
        end else begin
            sq_rgb_r <= inside_s ? sq_color : ~sq_color;
            if (frame_start && (hit_x_s || hit_y_s)) begin
                bounce_cnt_r <= bounce_cnt_r + CNT_W'(1);
            end else begin
                bounce_cnt_r <= bounce_cnt_r;
            end
        end
    end

    assign sq_rgb     = sq_rgb_r;
    assign bounce_cnt = bounce_cnt_r;

    logic unused_s;
    assign unused_s = dx_s ^ dy_s;

endmodule

// File: tb/tb_square_bounce_gen.sv
// Self-checking bench for square_bounce_gen against a frame-level arithmetic model of the bouncing square.
module tb_square_bounce_gen;

    localparam int H = 640;
    localparam int V = 480;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = 11'd0;
    logic [10:0] y = 11'd0;
    logic        frame_start = 1'b0;
    logic [1:0]  sq_size = 2'd0;
    logic [11:0] sq_color = 12'h000;
    logic        move_en = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [11:0] sq_rgb;
    logic [7:0]  bounce_cnt;
    logic [11:0] sq_rgb2;
    logic [1:0]  bounce_cnt2;

    int checks = 0;
    int errors = 0;

    int mcx, mcy, mdx, mdy, mbc;
    logic [11:0] exp_rgb;

    always #5 clk = ~clk;

    square_bounce_gen dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
        .sq_size(sq_size), .sq_color(sq_color), .move_en(move_en), .speed(speed),
        .sq_rgb(sq_rgb), .bounce_cnt(bounce_cnt)
    );

    square_bounce_gen #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
        .sq_size(sq_size), .sq_color(sq_color), .move_en(move_en), .speed(speed),
        .sq_rgb(sq_rgb2), .bounce_cnt(bounce_cnt2)
    );

    function automatic logic [11:0] model_pix(input int px, input int py);
        int h;
        h = 16 << sq_size;
        if (px > mcx - h && px < mcx + h && py > mcy - h && py < mcy + h)
            return sq_color;
        else
            return ~sq_color;
    endfunction

    task automatic model_frame();
        int h, st, cand;
        bit hit;
        h = 16 << sq_size;
        st = move_en ? int'(speed) : 0;
        hit = 1'b0;
        cand = mcx + mdx * st;
        if (cand > H - 1 - h) begin mcx = H - 1 - h; mdx = -1; hit = 1'b1; end
        else if (cand < h) begin mcx = h; mdx = 1; hit = 1'b1; end
        else mcx = cand;
        cand = mcy + mdy * st;
        if (cand > V - 1 - h) begin mcy = V - 1 - h; mdy = -1; hit = 1'b1; end
        else if (cand < h) begin mcy = h; mdy = 1; hit = 1'b1; end
        else mcy = cand;
        if (hit) mbc = mbc + 1;
    endtask

    // Advance one clock; model tracks what the DUT should hold just after the edge
    task automatic step();
        logic [11:0] e;
        e = model_pix(int'(x), int'(y));
        @(posedge clk);
        #1;
        if (reset) begin
            mcx = H / 2; mcy = V / 2; mdx = 1; mdy = 1; mbc = 0;
            exp_rgb = 12'h000;
        end else begin
            exp_rgb = e;
            if (frame_start) model_frame();
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; sq_color = 12'hF00; sq_size = 2'd0; x = 11'd320; y = 11'd240;
        move_en = 1'b0; speed = 4'd0;
        step();
        checks++;
        if (sq_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", sq_rgb); end
        checks++;
        if (bounce_cnt !== 8'd0 || bounce_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0", bounce_cnt, bounce_cnt2); end
        checks++;
        if (int'(dut.u_x.c_r) != 320 || int'(dut.u_y.c_r) != 240 || dut.u_x.dir_r !== 1'b0 || dut.u_y.dir_r !== 1'b0) begin
            errors++; $display("FAIL reset_centre got %0d,%0d exp 320,240", dut.u_x.c_r, dut.u_y.c_r);
        end
        reset = 1'b0;
        step();
        checks++;
        if (sq_rgb !== 12'hF00) begin errors++; $display("FAIL centre_pixel got %h exp F00", sq_rgb); end
        x = 11'd336;
        step();
        checks++;
        if (sq_rgb !== 12'h0FF) begin errors++; $display("FAIL edge_pixel got %h exp 0FF", sq_rgb); end
    endtask

    task automatic test_motion();
        move_en = 1'b1; speed = 4'd4;
        frame();
        checks++;
        if (int'(dut.u_x.c_r) != 324 || int'(dut.u_y.c_r) != 244) begin
            errors++; $display("FAIL first_move got %0d,%0d exp 324,244", dut.u_x.c_r, dut.u_y.c_r);
        end
        x = 11'd339; y = 11'd244;
        step();
        checks++;
        if (sq_rgb !== 12'hF00) begin errors++; $display("FAIL moved_inside got %h exp F00", sq_rgb); end
        x = 11'd340;
        step();
        checks++;
        if (sq_rgb !== 12'h0FF) begin errors++; $display("FAIL moved_edge got %h exp 0FF", sq_rgb); end
        for (int f = 2; f <= 76; f++) begin
            frame();
            checks++;
            if (int'(dut.u_x.c_r) != mcx || int'(dut.u_y.c_r) != mcy || int'(bounce_cnt) != mbc % 256) begin
                errors++; $display("FAIL motion_frame%0d got %0d,%0d,%0d exp %0d,%0d,%0d",
                                   f, dut.u_x.c_r, dut.u_y.c_r, bounce_cnt, mcx, mcy, mbc);
            end
            if (f == 56) begin
                checks++;
                if (int'(dut.u_y.c_r) != 463 || dut.u_y.dir_r !== 1'b1 || bounce_cnt !== 8'd1) begin
                    errors++; $display("FAIL y_clamp got %0d dir %b cnt %0d exp 463 1 1", dut.u_y.c_r, dut.u_y.dir_r, bounce_cnt);
                end
            end
            if (f == 57) begin
                checks++;
                if (int'(dut.u_y.c_r) != 459) begin errors++; $display("FAIL y_return got %0d exp 459", dut.u_y.c_r); end
            end
        end
        checks++;
        if (int'(dut.u_x.c_r) != 623 || bounce_cnt !== 8'd2) begin
            errors++; $display("FAIL x_clamp got %0d cnt %0d exp 623 2", dut.u_x.c_r, bounce_cnt);
        end
    endtask

    task automatic test_resize();
        sq_size = 2'd3; move_en = 1'b0;
        frame();
        checks++;
        if (int'(dut.u_y.c_r) != 351 || dut.u_y.dir_r !== 1'b1 || bounce_cnt !== 8'd3) begin
            errors++; $display("FAIL resize_clamp got %0d dir %b cnt %0d exp 351 1 3", dut.u_y.c_r, dut.u_y.dir_r, bounce_cnt);
        end
        x = 11'd400; y = 11'd300;
        step();
        checks++;
        if (sq_rgb !== exp_rgb) begin errors++; $display("FAIL resize_pixel got %h exp %h", sq_rgb, exp_rgb); end
    endtask

    task automatic test_reset_mid();
        sq_size = 2'd1; move_en = 1'b1; speed = 4'd7;
        for (int i = 0; i < 5; i++) begin frame(); step(); end
        reset = 1'b1; frame_start = 1'b1;
        step();
        reset = 1'b0; frame_start = 1'b0;
        checks++;
        if (sq_rgb !== 12'h000 || bounce_cnt !== 8'd0 || int'(dut.u_x.c_r) != 320 || int'(dut.u_y.c_r) != 240
            || dut.u_x.dir_r !== 1'b0 || dut.u_y.dir_r !== 1'b0) begin
            errors++; $display("FAIL mid_reset got rgb %h cnt %0d c %0d,%0d", sq_rgb, bounce_cnt, dut.u_x.c_r, dut.u_y.c_r);
        end
        frame();
        checks++;
        if (int'(dut.u_x.c_r) != 327 || int'(dut.u_y.c_r) != 247) begin
            errors++; $display("FAIL post_reset_move got %0d,%0d exp 327,247", dut.u_x.c_r, dut.u_y.c_r);
        end
    endtask

    task automatic test_corner();
        reset = 1'b1; step(); reset = 1'b0;
        sq_size = 2'd0; move_en = 1'b1; speed = 4'd4;
        for (int i = 0; i < 48; i++) frame();
        sq_size = 2'd3; move_en = 1'b0;
        frame();
        checks++;
        if (int'(dut.u_x.c_r) != 511 || int'(dut.u_y.c_r) != 351 || bounce_cnt !== 8'd1 || bounce_cnt2 !== 2'd1) begin
            errors++; $display("FAIL corner_hit got %0d,%0d cnt %0d/%0d exp 511,351 1/1",
                               dut.u_x.c_r, dut.u_y.c_r, bounce_cnt, bounce_cnt2);
        end
    endtask

    task automatic test_wrap();
        bit seen_wrap;
        logic [1:0] prev;
        seen_wrap = 1'b0;
        move_en = 1'b1; speed = 4'd15;
        for (int i = 0; i < 200; i++) begin
            sq_size = 2'($urandom_range(0, 3));
            prev = bounce_cnt2;
            frame();
            if (prev == 2'd3 && bounce_cnt2 == 2'd0) seen_wrap = 1'b1;
            checks++;
            if (int'(bounce_cnt2) != mbc % 4 || int'(bounce_cnt) != mbc % 256) begin
                errors++; $display("FAIL wrap_cnt got %0d/%0d exp %0d/%0d", bounce_cnt2, bounce_cnt, mbc % 4, mbc % 256);
            end
        end
        checks++;
        if (!seen_wrap) begin errors++; $display("FAIL wrap_seen got 0 exp 1"); end
    endtask

    task automatic test_random();
        int px, py;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) sq_size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) sq_color = 12'($urandom);
            if ($urandom_range(0, 99) == 0) move_en = 1'($urandom);
            if ($urandom_range(0, 99) == 0) speed = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                px = $urandom_range(0, H - 1); py = $urandom_range(0, V - 1);
            end else begin
                px = mcx + $urandom_range(0, 300) - 150; py = mcy + $urandom_range(0, 300) - 150;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
            end
            x = 11'(px); y = 11'(py);
            frame_start = ($urandom_range(0, 39) == 0);
            step();
            frame_start = 1'b0;
            checks++;
            if (sq_rgb !== exp_rgb || int'(bounce_cnt) != mbc % 256 || int'(bounce_cnt2) != mbc % 4) begin
                errors++; $display("FAIL random_pix%0d got %h cnt %0d exp %h cnt %0d", i, sq_rgb, bounce_cnt, exp_rgb, mbc % 256);
            end
        end
    endtask

    initial begin
        mcx = H / 2; mcy = V / 2; mdx = 1; mdy = 1; mbc = 0; exp_rgb = 12'h000;
        test_reset();
        test_motion();
        test_resize();
        test_reset_mid();
        test_corner();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
